pixel_cache_ctrl: RTL and testbench
===================================

Name: pixel_cache_ctrl

Overview:
- Sequencer for the 8-pixel, up-to-8-plane bit-plane pixel cache datapath.
- Accepts PLOT requests (column, colour) and loads them into the cache with one-hot pixel strobes.
- Tracks a dirty mask and flushes the cache to game-pak RAM one plane at a time.
- For a partial mask, each plane is a read-merge-write: it reads RAM into the bit-plane registers under ldram_n, then writes the merged byte.
- Sits between the plot/RPIX instruction decoder and the RAM bus arbiter.

Parameters:
ADDR_W, 17, RAM byte address width
FLUSH_ON_FULL, 1, 1 = start a flush automatically when the dirty mask reaches 8'hFF

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
plot_req  in  1  plot request; held until plot_ack
plot_x  in  3  pixel column within the 8-pixel row (0 = leftmost = data bit 7)
plot_color  in  8  colour; bit p goes to plane p
plot_base  in  ADDR_W  RAM byte address of plane 0 for this row
bpp_mode  in  2  0 = 2bpp, 1 = 4bpp, 3 = 8bpp, 2 = reserved (treated as 4bpp)
flush_req  in  1  explicit flush pulse (RPIX / end of frame)
plot_ack  out  1  one-cycle pulse: plot accepted and loaded
busy  out  1  high while flushing or while a plot is pending
ldpix_n  out  1  active-low pixel load strobe to the bit-plane datapath
pix_sel  out  8  one-hot column select qualifying ldpix_n (bit 7 = column 0)
col  out  8  per-plane colour bits for the loaded pixel
ldram_n  out  1  active-low strobe: merge RAM read data into non-dirty bits
plane_sel  out  3  plane currently being flushed (steers the dump/ram data mux)
ram_req  out  1  RAM transaction request; held until ram_ack
ram_we  out  1  1 = write, 0 = read; valid with ram_req
ram_addr  out  ADDR_W  RAM address; valid with ram_req
ram_ack  in  1  transaction complete when sampled high with ram_req

Behaviour:
- Reset values: all outputs inactive, i.e. ldpix_n = 1, ldram_n = 1, ram_req = 0, ram_we = 0, plot_ack = 0, busy = 0, pix_sel = 0, col = 0, plane_sel = 0, ram_addr = 0.
- Reset also clears dirty = 0, clears the cached base and returns to IDLE.
- Reset during a flush abandons it; cached pixels are discarded and RAM is left at whatever was last written.
- States: IDLE, LOAD, FL_RD, FL_MERGE, FL_WR, FL_NEXT.
- IDLE, priority order:
  - flush_req with dirty != 0 -> FL_RD or FL_WR.
  - flush_req with dirty = 0 -> no-op.
  - plot_req with dirty != 0 and plot_base != cached base -> flush first; the plot stays pending and busy = 1.
  - plot_req otherwise -> LOAD.
- LOAD (1 cycle):
  - Drive ldpix_n = 0, pix_sel = one-hot(plot_x), col = plot_color, plot_ack = 1.
  - Set dirty[7 - plot_x] and latch the cached base.
  - Next: if FLUSH_ON_FULL and dirty becomes 8'hFF -> flush; else IDLE.
  - Plot-to-ack latency is 1 cycle from sampling plot_req, when no flush is needed.
  - Re-plotting a dirty column overwrites it; the mask is unchanged.
- Flush start:
  - Latch nplanes = 2 / 4 / 8 from bpp_mode and set p = 0.
  - Plane address = base + {p[2:1], 4'b0} + p[0], which gives SNES planar offsets 0, 1, 16, 17, 32, 33, 48, 49. Arithmetic wraps modulo 2^ADDR_W.
- Per plane:
  - dirty == 8'hFF: go straight to FL_WR.
  - Otherwise: FL_RD (ram_req = 1, ram_we = 0) until ram_ack, then FL_MERGE (ldram_n = 0 for exactly 1 cycle), then FL_WR.
  - FL_WR: ram_req = 1, ram_we = 1 until ram_ack.
  - plane_sel = p throughout.
  - ram_addr and ram_we stay stable while ram_req is high.
- FL_NEXT: p++; if p == nplanes, clear dirty and return to IDLE (a pending plot is then served via LOAD); otherwise start the next plane.
- Cycle counts with zero-wait ram_ack (ack in the same cycle as req), excluding FL_NEXT bookkeeping, which is 1 cycle per plane:
  - full mask: 1 cycle per plane;
  - partial mask: 3 cycles per plane.
- ram_ack while ram_req = 0 is ignored.
- flush_req during a flush is ignored.
- busy = (state != IDLE) || pending plot.

Decomposition:
- Shared package pixel_cache_pkg holds:
  - state enum;
  - BPP_2 / BPP_4 / BPP_8 mode constants;
  - a plane_offset(p) function returning {p[2:1], 4'b0} + p[0].
- No sub-module needed; the address generator stays inline. An optional one-hot decoder may reuse the codebase's existing decoder.

Test Plan:
- Reset mid-flush (reset asserted while in FL_WR at p = 2) -> next cycle all outputs inactive, busy = 0, dirty = 0; a following plot loads normally.
- Plot x = 0,1,…,7 at base 0x01000 with colour 0x05, 2bpp, FLUSH_ON_FULL = 1, ram_ack tied 1:
  - each plot gives plot_ack one cycle later, with pix_sel 0x80…0x01 and col = 0x05;
  - then two writes, to 0x01000 and then 0x01001, with no reads.
- Plot x = 3 colour 0x0A, 4bpp, then flush_req:
  - four read / ldram_n / write triplets at 0x01000, 0x01001, 0x01010, 0x01011;
  - ldram_n low exactly 1 cycle per plane.
- Plot at base 0x01000, then plot at base 0x01020: flush of 0x01000 completes (busy = 1 throughout) before the second plot_ack.
- ram_ack delayed 3 cycles on a read: ram_req, ram_we = 0 and ram_addr held stable for 4 cycles; ldram_n asserted only after the ack.
- flush_req with empty cache -> no ram_req, busy stays 0; flush_req and plot_req in the same cycle with dirty != 0 -> flush first, plot_ack after return to IDLE.

Source files
------------

// File: rtl/pixel_cache_pkg.sv
// Shared types and helpers for the bit-plane pixel cache sequencer.
// Holds the FSM state encoding, bpp mode codes and planar address helpers.
package pixel_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FL_RD,
    ST_FL_MERGE,
    ST_FL_WR,
    ST_FL_NEXT
  } state_t;

  localparam logic [1:0] BPP_2 = 2'd0;
  localparam logic [1:0] BPP_4 = 2'd1;
  localparam logic [1:0] BPP_8 = 2'd3;

  // SNES planar layout: plane pairs interleave bytewise, pairs sit 16 bytes apart.
  function automatic logic [5:0] plane_offset(input logic [2:0] p);
    return {p[2:1], 4'b0000} + {5'b00000, p[0]};
  endfunction

  // Reserved mode 2 behaves as 4bpp.
  function automatic logic [3:0] plane_count(input logic [1:0] bpp);
    logic [3:0] n;
    case (bpp)
      BPP_2:   n = 4'd2;
      BPP_8:   n = 4'd8;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pixel_cache_ctrl.sv
// Sequencer for the 8-pixel bit-plane pixel cache: loads plotted pixels and
// flushes dirty rows to RAM one plane at a time, merging partial rows.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for plot_req / flush_req
// ST_LOAD     | one-cycle pixel load into the cache, plot_ack pulsed
// ST_FL_RD    | reading current plane from RAM (partial mask only)
// ST_FL_MERGE | ldram_n low: RAM data merged into non-dirty bits
// ST_FL_WR    | writing the current plane byte to RAM
// ST_FL_NEXT  | advance plane, or finish flush and clear dirty mask
module pixel_cache_ctrl
  import pixel_cache_pkg::*;
#(
  parameter int ADDR_W        = 17,
  parameter bit FLUSH_ON_FULL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              plot_req,
  input  logic [2:0]        plot_x,
  input  logic [7:0]        plot_color,
  input  logic [ADDR_W-1:0] plot_base,
  input  logic [1:0]        bpp_mode,
  input  logic              flush_req,
  output logic              plot_ack,
  output logic              busy,
  output logic              ldpix_n,
  output logic [7:0]        pix_sel,
  output logic [7:0]        col,
  output logic              ldram_n,
  output logic [2:0]        plane_sel,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack
);

  state_t              r_state;
  logic [7:0]          r_dirty;
  logic [ADDR_W-1:0]   r_base;
  logic                r_pending;
  logic [2:0]          r_p;
  logic [3:0]          r_nplanes;
  logic                r_plot_ack;
  logic                r_ldpix_n;
  logic [7:0]          r_pix_sel;
  logic [7:0]          r_col;
  logic                r_ldram_n;
  logic                r_ram_req;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;

  logic                w_full;
  logic                w_base_miss;
  logic                w_ram_done;
  logic                w_last_plane;
  logic [2:0]          w_next_p;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [7:0]          w_col_onehot;

  assign w_full       = (r_dirty == 8'hFF);
  assign w_base_miss  = (r_dirty != 8'h00) && (plot_base != r_base);
  assign w_ram_done   = r_ram_req && ram_ack;
  assign w_next_p     = r_p + 3'd1;
  assign w_last_plane = ({1'b0, r_p} + 4'd1) == r_nplanes;
  assign w_next_addr  = r_base + ADDR_W'(plane_offset(w_next_p));
  assign w_col_onehot = 8'h80 >> plot_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dirty    <= 8'h00;
      r_base     <= '0;
      r_pending  <= 1'b0;
      r_p        <= 3'd0;
      r_nplanes  <= 4'd0;
      r_plot_ack <= 1'b0;
      r_ldpix_n  <= 1'b1;
      r_pix_sel  <= 8'h00;
      r_col      <= 8'h00;
      r_ldram_n  <= 1'b1;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A plot to a different row must flush the cached row first.
          if ((flush_req && r_dirty != 8'h00) || (plot_req && w_base_miss)) begin
            r_pending  <= plot_req;
            r_nplanes  <= plane_count(bpp_mode);
            r_p        <= 3'd0;
            r_ram_req  <= 1'b1;
            r_ram_we   <= w_full;
            r_ram_addr <= r_base;
            r_state    <= w_full ? ST_FL_WR : ST_FL_RD;
          end else if (plot_req) begin
            r_pending  <= 1'b0;
            r_plot_ack <= 1'b1;
            r_ldpix_n  <= 1'b0;
            r_pix_sel  <= w_col_onehot;
            r_col      <= plot_color;
            r_dirty    <= r_dirty | w_col_onehot;
            r_base     <= plot_base;
            r_state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_plot_ack <= 1'b0;
          r_ldpix_n  <= 1'b1;
          r_pix_sel  <= 8'h00;
          r_col      <= 8'h00;
          if (FLUSH_ON_FULL && w_full) begin
            r_nplanes  <= plane_count(bpp_mode);
            r_p        <= 3'd0;
            r_ram_req  <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_base;
            r_state    <= ST_FL_WR;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_FL_RD: begin
          if (w_ram_done) begin
            r_ram_req <= 1'b0;
            r_ldram_n <= 1'b0;
            r_state   <= ST_FL_MERGE;
          end
        end

        ST_FL_MERGE: begin
          r_ldram_n <= 1'b1;
          r_ram_req <= 1'b1;
          r_ram_we  <= 1'b1;
          r_state   <= ST_FL_WR;
        end

        ST_FL_WR: begin
          if (w_ram_done) begin
            r_ram_req <= 1'b0;
            r_state   <= ST_FL_NEXT;
          end
        end

        ST_FL_NEXT: begin
          if (w_last_plane) begin
            r_dirty  <= 8'h00;
            r_p      <= 3'd0;
            r_ram_we <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_p        <= w_next_p;
            r_ram_req  <= 1'b1;
            r_ram_we   <= w_full;
            r_ram_addr <= w_next_addr;
            r_state    <= w_full ? ST_FL_WR : ST_FL_RD;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign plot_ack  = r_plot_ack;
  assign busy      = (r_state != ST_IDLE) || r_pending;
  assign ldpix_n   = r_ldpix_n;
  assign pix_sel   = r_pix_sel;
  assign col       = r_col;
  assign ldram_n   = r_ldram_n;
  assign plane_sel = r_p;
  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;

endmodule

// File: tb/tb_pixel_cache_ctrl.sv
// Self-checking bench for pixel_cache_ctrl: RAM responder with scoreboard of
// expected transactions, plus per-scenario tasks checking plots and flushes.
module tb_pixel_cache_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          plot_req = 1'b0;
  logic [2:0]    plot_x = 3'd0;
  logic [7:0]    plot_color = 8'h00;
  logic [AW-1:0] plot_base = '0;
  logic [1:0]    bpp_mode = 2'd0;
  logic          flush_req = 1'b0;
  logic          plot_ack, busy, ldpix_n, ldram_n, ram_req, ram_we;
  logic [7:0]    pix_sel, col;
  logic [2:0]    plane_sel;
  logic [AW-1:0] ram_addr;
  logic          ram_ack = 1'b0;

  pixel_cache_ctrl #(.ADDR_W(AW), .FLUSH_ON_FULL(1'b1)) dut (
    .clk(clk), .reset(reset), .plot_req(plot_req), .plot_x(plot_x),
    .plot_color(plot_color), .plot_base(plot_base), .bpp_mode(bpp_mode),
    .flush_req(flush_req), .plot_ack(plot_ack), .busy(busy), .ldpix_n(ldpix_n),
    .pix_sel(pix_sel), .col(col), .ldram_n(ldram_n), .plane_sel(plane_sel),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [AW-1:0] addr; } txn_t;
  txn_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay = 0;
  bit hold_en = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  int rd_cnt = 0, ldram_cnt = 0, last_rd_len = 0;

  bit prev_req = 0, prev_ack = 0, prev_we = 0, prev_rd_done = 0;
  logic [AW-1:0] prev_addr = '0;
  int wait_cnt = 0;

  // RAM responder and transaction monitor, evaluated 1 time unit after each edge.
  always @(posedge clk) begin
    txn_t got, exp;
    #1;
    if (reset) begin
      ram_ack = 1'b0; prev_req = 0; prev_ack = 0; prev_rd_done = 0; wait_cnt = 0;
    end else begin
      if (prev_req && !prev_ack && ram_req) begin
        n_checks++;
        if (ram_addr !== prev_addr || ram_we !== prev_we) begin
          n_errors++;
          $display("FAIL req_stable: addr %h we %b, required addr %h we %b", ram_addr, ram_we, prev_addr, prev_we);
        end
      end
      if (ram_req) wait_cnt = (prev_req && !prev_ack) ? wait_cnt + 1 : 0;
      else wait_cnt = 0;
      ram_ack = ram_req && (wait_cnt >= ack_delay) && !(hold_en && ram_we && ram_addr == hold_addr);
      if (prev_rd_done || ldram_n === 1'b0) begin
        n_checks++;
        if (ldram_n !== ~prev_rd_done) begin
          n_errors++;
          $display("FAIL ldram_merge: ldram_n %b, required %b", ldram_n, ~prev_rd_done);
        end
        if (ldram_n === 1'b0) ldram_cnt++;
      end
      prev_rd_done = 0;
      if (ram_ack) begin
        got = {ram_we, ram_addr};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL ram_txn: got we %b addr %h, required no transaction", ram_we, ram_addr);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_errors++;
            $display("FAIL ram_txn: got we %b addr %h, required we %b addr %h", got.we, got.addr, exp.we, exp.addr);
          end
        end
        if (!ram_we) begin
          rd_cnt++; last_rd_len = wait_cnt + 1; prev_rd_done = 1;
        end
      end
      prev_req = ram_req; prev_ack = ram_ack; prev_we = ram_we; prev_addr = ram_addr;
    end
  end

  task automatic push_rw(input logic [AW-1:0] a);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, a});
  endtask

  task automatic do_plot(input logic [2:0] x, input logic [7:0] c, input logic [AW-1:0] b, output int lat);
    @(negedge clk);
    plot_x = x; plot_color = c; plot_base = b; plot_req = 1'b1; lat = 0;
    do begin @(negedge clk); lat++; end while (plot_ack !== 1'b1 && lat < 300);
    plot_req = 1'b0;
    if (plot_ack !== 1'b1) lat = -1;
  endtask

  task automatic pulse_flush;
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 500);
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ldpix_n, ldram_n, ram_req, ram_we, plot_ack, busy} !== 6'b110000) begin
      n_errors++;
      $display("FAIL reset_ctl: ldpix/ldram/req/we/ack/busy %b, required 110000", {ldpix_n, ldram_n, ram_req, ram_we, plot_ack, busy});
    end
    n_checks++;
    if ({pix_sel, col, plane_sel, ram_addr} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: pix_sel %h col %h plane_sel %0d addr %h, required all 0", pix_sel, col, plane_sel, ram_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_mask;
    int lat; bit ok; int r0; logic [7:0] e;
    bpp_mode = 2'd0; r0 = rd_cnt;
    exp_q.push_back({1'b1, 17'h01000});
    exp_q.push_back({1'b1, 17'h01001});
    for (int x = 0; x < 8; x++) begin
      e = 8'h80 >> x;
      do_plot(3'(x), 8'h05, 17'h01000, lat);
      n_checks++;
      if (lat != 1) begin n_errors++; $display("FAIL full_lat x%0d: %0d, required 1", x, lat); end
      n_checks++;
      if (pix_sel !== e || ldpix_n !== 1'b0) begin
        n_errors++; $display("FAIL full_pix x%0d: pix_sel %h ldpix_n %b, required %h 0", x, pix_sel, ldpix_n, e);
      end
      n_checks++;
      if (col !== 8'h05) begin n_errors++; $display("FAIL full_col x%0d: %h, required 05", x, col); end
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL full_flush: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
    n_checks++;
    if (rd_cnt != r0) begin n_errors++; $display("FAIL full_noread: reads %0d, required 0", rd_cnt - r0); end
  endtask

  task automatic test_partial_4bpp;
    int lat; bit ok; int l0;
    bpp_mode = 2'd1; l0 = ldram_cnt;
    push_rw(17'h01000); push_rw(17'h01001); push_rw(17'h01010); push_rw(17'h01011);
    do_plot(3'd3, 8'h0A, 17'h01000, lat);
    n_checks++;
    if (lat != 1 || pix_sel !== 8'h10 || col !== 8'h0A) begin
      n_errors++; $display("FAIL part_plot: lat %0d pix_sel %h col %h, required 1 10 0a", lat, pix_sel, col);
    end
    pulse_flush;
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL part_flush: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
    n_checks++;
    if (ldram_cnt - l0 != 4) begin n_errors++; $display("FAIL part_ldram: %0d pulses, required 4", ldram_cnt - l0); end
  endtask

  task automatic test_base_change;
    int lat; bit ok; bit busy_lo;
    bpp_mode = 2'd0;
    do_plot(3'd0, 8'h03, 17'h01000, lat);
    n_checks++;
    if (lat != 1) begin n_errors++; $display("FAIL base_first_lat: %0d, required 1", lat); end
    push_rw(17'h01000); push_rw(17'h01001);
    @(negedge clk);
    plot_x = 3'd1; plot_color = 8'hC3; plot_base = 17'h01020; plot_req = 1'b1; lat = 0; busy_lo = 0;
    do begin
      @(negedge clk); lat++;
      if (busy !== 1'b1) busy_lo = 1;
    end while (plot_ack !== 1'b1 && lat < 300);
    plot_req = 1'b0;
    n_checks++;
    if (lat != 10) begin n_errors++; $display("FAIL base_lat: %0d, required 10", lat); end
    n_checks++;
    if (busy_lo || exp_q.size() != 0) begin
      n_errors++; $display("FAIL base_order: busy dropped %b pending txns %0d, required 0 0", busy_lo, exp_q.size());
    end
    push_rw(17'h01020); push_rw(17'h01021);
    pulse_flush;
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL base_flush2: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_delayed_ack;
    int lat; bit ok; int l0;
    bpp_mode = 2'd0; ack_delay = 3;
    push_rw(17'h02000); push_rw(17'h02001);
    do_plot(3'd6, 8'h02, 17'h02000, lat);
    n_checks++;
    if (lat != 1 || pix_sel !== 8'h02) begin
      n_errors++; $display("FAIL delay_plot: lat %0d pix_sel %h, required 1 02", lat, pix_sel);
    end
    l0 = ldram_cnt;
    pulse_flush;
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL delay_flush: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
    n_checks++;
    if (last_rd_len != 4 || ldram_cnt - l0 != 2) begin
      n_errors++; $display("FAIL delay_rd: req cycles %0d ldram pulses %0d, required 4 2", last_rd_len, ldram_cnt - l0);
    end
    ack_delay = 0;
  endtask

  task automatic test_empty_and_concurrent;
    int lat; bit ok; bit seen;
    seen = 0;
    pulse_flush;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || ram_req !== 1'b0) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_errors++; $display("FAIL empty_flush: busy/ram_req seen 1, required 0"); end
    bpp_mode = 2'd0;
    do_plot(3'd5, 8'h11, 17'h03000, lat);
    n_checks++;
    if (lat != 1) begin n_errors++; $display("FAIL conc_first_lat: %0d, required 1", lat); end
    push_rw(17'h03000); push_rw(17'h03001);
    @(negedge clk);
    flush_req = 1'b1; plot_x = 3'd6; plot_color = 8'h22; plot_base = 17'h03000; plot_req = 1'b1; lat = 0;
    do begin @(negedge clk); flush_req = 1'b0; lat++; end while (plot_ack !== 1'b1 && lat < 300);
    plot_req = 1'b0;
    n_checks++;
    if (lat != 10 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL conc_order: lat %0d pending txns %0d, required 10 0", lat, exp_q.size());
    end
    n_checks++;
    if (pix_sel !== 8'h02 || col !== 8'h22) begin
      n_errors++; $display("FAIL conc_pix: pix_sel %h col %h, required 02 22", pix_sel, col);
    end
    push_rw(17'h03000); push_rw(17'h03001);
    pulse_flush;
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL conc_flush2: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_flush;
    int lat; bit ok; int n;
    bpp_mode = 2'd1;
    do_plot(3'd2, 8'h0F, 17'h04000, lat);
    n_checks++;
    if (lat != 1) begin n_errors++; $display("FAIL rmf_plot_lat: %0d, required 1", lat); end
    hold_addr = 17'h04010; hold_en = 1'b1;
    push_rw(17'h04000); push_rw(17'h04001);
    exp_q.push_back({1'b0, 17'h04010});
    pulse_flush;
    n = 0;
    while (!(ram_req === 1'b1 && ram_we === 1'b1 && ram_addr === 17'h04010) && n < 200) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 200 || plane_sel !== 3'd2) begin
      n_errors++; $display("FAIL rmf_reach: timeout %b plane_sel %0d, required 0 2", n >= 200, plane_sel);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ldpix_n, ldram_n, ram_req, ram_we, plot_ack, busy} !== 6'b110000) begin
      n_errors++;
      $display("FAIL rmf_ctl: ldpix/ldram/req/we/ack/busy %b, required 110000", {ldpix_n, ldram_n, ram_req, ram_we, plot_ack, busy});
    end
    n_checks++;
    if ({pix_sel, col, plane_sel, ram_addr} !== '0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rmf_data: pix_sel %h col %h plane_sel %0d addr %h pending %0d, required all 0", pix_sel, col, plane_sel, ram_addr, exp_q.size());
    end
    reset = 1'b0; hold_en = 1'b0; bpp_mode = 2'd0;
    do_plot(3'd7, 8'h81, 17'h05000, lat);
    n_checks++;
    if (lat != 1 || pix_sel !== 8'h01 || col !== 8'h81) begin
      n_errors++; $display("FAIL rmf_replot: lat %0d pix_sel %h col %h, required 1 01 81", lat, pix_sel, col);
    end
    push_rw(17'h05000); push_rw(17'h05001);
    pulse_flush;
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_errors++; $display("FAIL rmf_flush: idle %b pending txns %0d, required 1 0", ok, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_full_mask;
    test_partial_4bpp;
    test_base_change;
    test_delayed_ack;
    test_empty_and_concurrent;
    test_reset_mid_flush;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
